// File: rtl/ex_pkg.sv
// Types shared by the EX and WB stages: the latched EX result record and
// the helper that derives its Z/N flags.
package ex_pkg;

    localparam int EX_DATA_W = 32;
    localparam int EX_REG_AW = 5;

    typedef struct packed {
        logic [EX_DATA_W-1:0] result;
        logic [EX_REG_AW-1:0] dst;
        logic                 wb_en;
        logic                 zero;
        logic                 neg;
    } ex_res_t;

    // Flags are computed once here and stored with the entry.
    function automatic ex_res_t make_res(
        input logic [EX_DATA_W-1:0] result,
        input logic [EX_REG_AW-1:0] dst,
        input logic                 wb_en
    );
        ex_res_t r;
        r.result = result;
        r.dst    = dst;
        r.wb_en  = wb_en;
        r.zero   = (result == '0);
        r.neg    = result[EX_DATA_W-1];
        return r;
    endfunction

endpackage

// File: rtl/ex_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO. The ready and valid outputs are both
// registered, so neither handshake side sees a combinational path.
module ex_skid_fifo2
    import ex_pkg::*;
#(
    parameter type T = ex_res_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    T           mem_q [2];
    logic       wr_q, rd_q;
    logic [1:0] count_q, count_d;
    logic       in_ready_q, out_valid_q;
    logic       push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Flush wins over push/pop; a pop in the flush cycle is still accepted
    // downstream, so nothing extra is needed here for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q[0]    <= T'('0);
            mem_q[1]    <= T'('0);
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            count_q     <= 2'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop)
                rd_q <= ~rd_q;
            count_q     <= count_d;
            in_ready_q  <= (count_d < 2'd2);
            out_valid_q <= (count_d != 2'd0);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = mem_q[rd_q];

endmodule

// File: rtl/ex_result_latch.sv
// EX result latch: flags the incoming result, buffers it in a 2-entry skid
// FIFO toward writeback, and forwards the head entry to the bypass network.
module ex_result_latch
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_AW = EX_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_wb_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_wb_en,
    output logic              out_zero,
    output logic              out_neg,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_dst,
    output logic [DATA_W-1:0] fwd_data
);

    ex_res_t in_res, head;

    assign in_res = make_res(in_result, in_dst, in_wb_en);

    ex_skid_fifo2 #(.T(ex_res_t)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_result = head.result;
    assign out_dst    = head.dst;
    assign out_wb_en  = head.wb_en;
    assign out_zero   = head.zero;
    assign out_neg    = head.neg;

    // r0 is hardwired, so a write to it must never be bypassed.
    assign fwd_valid = out_valid & head.wb_en & (head.dst != '0);
    assign fwd_dst   = head.dst;
    assign fwd_data  = head.result;

endmodule
